// File: rtl/tail_light_pkg.sv
// tail_light_pkg: shared mode encoding and lamp pattern helper for the tail-light sequencer
package tail_light_pkg;
  typedef enum logic [1:0] {MODE_IDLE, MODE_LEFT, MODE_RIGHT, MODE_HAZARD} mode_t;
  function automatic int lamp_pattern(input int phase, input int n);
    return (1 << (phase > n ? n : phase)) - 1;
  endfunction
endpackage

// File: rtl/tail_light_step_timer.sv
// tail_light_step_timer: prescaler and phase counter; phase is the value for the coming cycle
module tail_light_step_timer #(
  parameter int N_LAMPS = 3,
  parameter int STEP_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic [$clog2(N_LAMPS+1)-1:0] phase
);
  localparam int PW = $clog2(N_LAMPS+1);
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  logic [SW-1:0] presc, presc_nxt;
  logic [PW-1:0] phase_q;
  logic clear, wrap;
  always_comb begin
    clear = restart || !run;
    wrap = presc == SW'(STEP_CYCLES-1);
    presc_nxt = (clear || wrap) ? '0 : presc + 1'b1;
    phase = clear ? '0 : !wrap ? phase_q : (phase_q == PW'(N_LAMPS)) ? '0 : phase_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      phase_q <= '0;
    end else begin
      presc <= presc_nxt;
      phase_q <= phase;
    end
  end
endmodule

// File: rtl/tail_light_sequencer.sv
// tail_light_sequencer: sequential-turn / hazard / brake rear-lamp controller with registered outputs
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int N_LAMPS = 3,
  parameter int STEP_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic brake,
  input  logic turn_left,
  input  logic turn_right,
  input  logic hazard,
  output logic [N_LAMPS-1:0] left_lamps,
  output logic [N_LAMPS-1:0] right_lamps,
  output logic [$clog2(N_LAMPS+1)-1:0] seq_phase,
  output logic seq_active
);
  mode_t mode, mode_d;
  logic [$clog2(N_LAMPS+1)-1:0] phase;
  logic [N_LAMPS-1:0] pat;
  logic left_seq, right_seq;
  always_comb begin
    mode_d = (hazard || (turn_left && turn_right)) ? MODE_HAZARD :
             turn_left ? MODE_LEFT : turn_right ? MODE_RIGHT : MODE_IDLE;
    left_seq = mode_d == MODE_LEFT || mode_d == MODE_HAZARD;
    right_seq = mode_d == MODE_RIGHT || mode_d == MODE_HAZARD;
    pat = N_LAMPS'(lamp_pattern(int'(phase), N_LAMPS));
  end
  tail_light_step_timer #(.N_LAMPS(N_LAMPS), .STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .restart(mode_d != mode),
    .run(mode_d != MODE_IDLE),
    .phase(phase)
  );
  // Outputs are registered from the decoded mode so lamps follow inputs with one edge of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= MODE_IDLE;
      left_lamps <= '0;
      right_lamps <= '0;
      seq_phase <= '0;
      seq_active <= 1'b0;
    end else begin
      mode <= mode_d;
      left_lamps <= left_seq ? pat : {N_LAMPS{brake}};
      right_lamps <= right_seq ? pat : {N_LAMPS{brake}};
      seq_phase <= phase;
      seq_active <= mode_d != MODE_IDLE;
    end
  end
endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb_tail_light_sequencer: table vectors plus model-driven scoreboard sequences
module tb_tail_light_sequencer;
  localparam int N = 3;
  localparam int S = 5;
  logic clk = 1'b0;
  logic rst = 1'b1, brake = 1'b0, turn_left = 1'b0, turn_right = 1'b0, hazard = 1'b0;
  logic [N-1:0] left_lamps, right_lamps;
  logic [1:0] seq_phase;
  logic seq_active;
  typedef struct packed {logic [2:0] l; logic [2:0] r; logic [1:0] ph; logic act;} out_t;
  typedef struct {logic rst, b, tl, tr, hz; logic [2:0] l, r; logic [1:0] ph; logic act; string name;} vec_t;
  out_t sb[$];
  int n_vec = 0, n_bad = 0, m_mode = 0, m_cnt = 0;
  vec_t tbl[15];

  tail_light_sequencer #(.N_LAMPS(N), .STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
    .hazard(hazard), .left_lamps(left_lamps), .right_lamps(right_lamps),
    .seq_phase(seq_phase), .seq_active(seq_active)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic r, b, tl, tr, hz, input bit use_tbl, input out_t texp, input string name);
    out_t m, got, e;
    int d, ph;
    @(negedge clk);
    rst = r; brake = b; turn_left = tl; turn_right = tr; hazard = hz;
    d = (hz || (tl && tr)) ? 3 : tl ? 1 : tr ? 2 : 0;
    m = '0;
    if (r) begin
      m_mode = 0;
      m_cnt = 0;
    end else begin
      m_cnt = (d == m_mode && d != 0) ? m_cnt + 1 : 0;
      m_mode = d;
      ph = (m_cnt / S) % (N + 1);
      m.ph = ph[1:0];
      m.act = d != 0;
      m.l = (d == 1 || d == 3) ? 3'((1 << ph) - 1) : {3{b}};
      m.r = (d == 2 || d == 3) ? 3'((1 << ph) - 1) : {3{b}};
    end
    sb.push_back(use_tbl ? texp : m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    got = {left_lamps, right_lamps, seq_phase, seq_active};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got l=%b r=%b ph=%0d act=%b, expected l=%b r=%b ph=%0d act=%b",
               name, $time, got.l, got.r, got.ph, got.act, e.l, e.r, e.ph, e.act);
    end
  endtask

  task automatic run(input int n, input logic r, b, tl, tr, hz, input string name);
    for (int i = 0; i < n; i++) apply(r, b, tl, tr, hz, 1'b0, '0, name);
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, "reset0"},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, "reset1"},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, "reset2"},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, "release"},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 2'd0, 1'b0, "brake_idle"},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, "brake_release"},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 2'd0, 1'b1, "left_brake_p0"},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 2'd0, 1'b1, "left_brake_p0"},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 2'd0, 1'b1, "left_brake_p0"},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 2'd0, 1'b1, "left_brake_p0"},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 2'd0, 1'b1, "left_brake_p0"},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 3'd7, 2'd1, 1'b1, "left_brake_p1"},
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 2'd1, 1'b1, "brake_drop"},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b0, "idle"},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 1'b1, "hazard_brake"}
    };
    foreach (tbl[i])
      apply(tbl[i].rst, tbl[i].b, tbl[i].tl, tbl[i].tr, tbl[i].hz, 1'b1,
            '{tbl[i].l, tbl[i].r, tbl[i].ph, tbl[i].act}, tbl[i].name);
    run(25, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "hazard_brake_seq");
    run(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid");
    run(40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "right_seq");
    run(22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "both_as_hazard");
    run(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_gap");
    run(13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "right_to_p2c3");
    run(12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "switch_left");
    run(17, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "right_to_p3");
    run(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "reset_in_p3");
    run(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "right_after_reset");
    run(7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "right_brake");
    run(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "right_drop");
    run(7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "right_reassert");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
